// File: rtl/deadlock_mon_pkg.sv
// deadlock_mon_pkg: shared FSM state, source-index width helper and event counter width for the deadlock monitor.
package deadlock_mon_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, BLOCKED} state_e;
  localparam int EVT_W = 16;
  function automatic int src_w(input int n_axis);
    return $clog2(n_axis + 1);
  endfunction
endpackage

// File: rtl/deadlock_prio_enc.sv
// deadlock_prio_enc: lowest-index priority encoder with a valid flag.
module deadlock_prio_enc #(
  parameter int W  = 3,
  parameter int OW = 2
) (
  input  logic [W-1:0]  req,
  output logic [OW-1:0] idx,
  output logic          valid
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) if (req[i]) idx = OW'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/deadlock_persist_monitor.sv
// deadlock_persist_monitor: declares a block once a candidate persists THRESH cycles; tracks source, sticky flag and events.
// Optional macro DEADLOCK_MON_INST_EN adds the instance idle/blocked deadlock term to the candidate.
module deadlock_persist_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int N_AXIS = 3,
  parameter int N_INST = 5,
  parameter int N_IBLK = 2,
  parameter int THRESH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_AXIS-1:0]           axis_block_sigs,
  input  logic [N_AXIS-1:0]           axis_mask,
  input  logic [N_INST-1:0]           inst_idle_sigs,
  input  logic [N_IBLK-1:0]           inst_block_sigs,
  input  logic                        clear,
  output logic                        block,
  output logic                        block_sticky,
  output logic [src_w(N_AXIS)-1:0]    block_src,
  output logic [EVT_W-1:0]            event_cnt
);
  localparam int SRC_W = src_w(N_AXIS);
  localparam logic [15:0] TH = 16'(THRESH);
  localparam logic [SRC_W-1:0] INST_SRC = SRC_W'(N_AXIS);
  logic [N_AXIS-1:0] axis_hit;
  logic [SRC_W-1:0] axis_idx;
  logic axis_valid, inst_dl, cand, entry;
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic block_q, block_d, sticky_q, sticky_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  assign axis_hit = axis_block_sigs & axis_mask;
  deadlock_prio_enc #(.W(N_AXIS), .OW(SRC_W)) u_prio (
    .req  (axis_hit),
    .idx  (axis_idx),
    .valid(axis_valid)
  );
`ifdef DEADLOCK_MON_INST_EN
  assign inst_dl = (|inst_block_sigs) & (&inst_idle_sigs);
`else
  logic unused_inst;
  assign inst_dl = 1'b0;
  assign unused_inst = ^{inst_idle_sigs, inst_block_sigs};
`endif
  assign cand = axis_valid | inst_dl;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    src_d = src_q;
    case (state_q)
      IDLE: if (cand) begin
        state_d = (TH == 16'd1) ? BLOCKED : COUNT;
        cnt_d = 16'd1;
        src_d = axis_valid ? axis_idx : INST_SRC;
      end
      COUNT: begin
        cnt_d = cand ? cnt_q + 16'd1 : 16'd0;
        state_d = !cand ? IDLE : (cnt_d == TH) ? BLOCKED : COUNT;
      end
      BLOCKED: if (!cand) begin
        state_d = IDLE;
        cnt_d = 16'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d = 16'd0;
      end
    endcase
    entry = (state_d == BLOCKED) && (state_q != BLOCKED);
    block_d = state_d == BLOCKED;
    sticky_d = entry | (sticky_q & ~clear);
    evt_d = entry ? (clear ? EVT_W'(1) : (&evt_q) ? evt_q : evt_q + EVT_W'(1))
                  : (clear ? '0 : evt_q);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      src_q <= '0;
      block_q <= 1'b0;
      sticky_q <= 1'b0;
      evt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      src_q <= src_d;
      block_q <= block_d;
      sticky_q <= sticky_d;
      evt_q <= evt_d;
    end
  end
  assign block = block_q;
  assign block_sticky = sticky_q;
  assign block_src = src_q;
  assign event_cnt = evt_q;
endmodule

// File: tb/tb_deadlock_persist_monitor.sv
// tb_deadlock_persist_monitor: directed and random checks of three monitors (THRESH 4, 2, 1) against a run-length model.
module tb_deadlock_persist_monitor;
  logic clock = 0, reset = 1, clear = 0;
  logic [2:0] axis = 0, mask = 0;
  logic [4:0] idle = 0;
  logic [1:0] iblk = 0;
  logic [2:0] blk, stk;
  logic [1:0] src_o [3];
  logic [15:0] ev [3];
  int n_chk = 0, n_fail = 0;
  int run [3], m_evt [3], m_src [3];
  bit m_stk [3];

  always #5 clock = ~clock;

  deadlock_persist_monitor #(.THRESH(4)) dut0 (.clock(clock), .reset(reset), .axis_block_sigs(axis),
    .axis_mask(mask), .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clear),
    .block(blk[0]), .block_sticky(stk[0]), .block_src(src_o[0]), .event_cnt(ev[0]));
  deadlock_persist_monitor #(.THRESH(2)) dut1 (.clock(clock), .reset(reset), .axis_block_sigs(axis),
    .axis_mask(mask), .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clear),
    .block(blk[1]), .block_sticky(stk[1]), .block_src(src_o[1]), .event_cnt(ev[1]));
  deadlock_persist_monitor #(.THRESH(1)) dut2 (.clock(clock), .reset(reset), .axis_block_sigs(axis),
    .axis_mask(mask), .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clear),
    .block(blk[2]), .block_sticky(stk[2]), .block_src(src_o[2]), .event_cnt(ev[2]));

  function automatic int th(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  function automatic bit m_cand();
    bit c;
    c = |(axis & mask);
`ifdef DEADLOCK_MON_INST_EN
    c = c | ((|iblk) & (&idle));
`endif
    return c;
  endfunction

  function automatic int m_low();
    for (int i = 0; i < 3; i++) if (axis[i] & mask[i]) return i;
    return 3;
  endfunction

  // A block is simply "candidate true for at least THRESH consecutive edges".
  task automatic tick();
    int nr;
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        run[k] = 0; m_evt[k] = 0; m_src[k] = 0; m_stk[k] = 0;
      end else begin
        nr = m_cand() ? run[k] + 1 : 0;
        if (nr == 1) m_src[k] = m_low();
        if (nr == th(k)) begin
          m_stk[k] = 1;
          m_evt[k] = clear ? 1 : (m_evt[k] < 65535 ? m_evt[k] + 1 : 65535);
        end else if (clear) begin
          m_stk[k] = 0; m_evt[k] = 0;
        end
        run[k] = nr;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; axis = 0; mask = 3'b111; clear = 0; idle = 0; iblk = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      n_chk += 4;
      if (blk[k] !== 1'b0) begin n_fail++; $display("FAIL reset_block k=%0d got %b exp 0", k, blk[k]); end
      if (stk[k] !== 1'b0) begin n_fail++; $display("FAIL reset_sticky k=%0d got %b exp 0", k, stk[k]); end
      if (src_o[k] !== 2'd0) begin n_fail++; $display("FAIL reset_src k=%0d got %0d exp 0", k, src_o[k]); end
      if (ev[k] !== 16'd0) begin n_fail++; $display("FAIL reset_evt k=%0d got %0d exp 0", k, ev[k]); end
    end
    reset = 0;
  endtask

  task automatic test_persist();
    do_reset();
    axis = 3'b010;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_chk++;
      if (blk[0] !== (e == 4)) begin n_fail++; $display("FAIL persist_block edge=%0d got %b exp %b", e, blk[0], e == 4); end
    end
    n_chk += 3;
    if (src_o[0] !== 2'd1) begin n_fail++; $display("FAIL persist_src got %0d exp 1", src_o[0]); end
    if (ev[0] !== 16'd1) begin n_fail++; $display("FAIL persist_evt got %0d exp 1", ev[0]); end
    if (stk[0] !== 1'b1) begin n_fail++; $display("FAIL persist_sticky got %b exp 1", stk[0]); end
  endtask

  task automatic test_restart();
    do_reset();
    axis = 3'b001;
    repeat (3) tick();
    axis = 3'b000;
    tick();
    axis = 3'b001;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_chk++;
      if (blk[0] !== (e == 4)) begin n_fail++; $display("FAIL restart_block edge=%0d got %b exp %b", e, blk[0], e == 4); end
    end
    n_chk++;
    if (ev[0] !== 16'd1) begin n_fail++; $display("FAIL restart_evt got %0d exp 1", ev[0]); end
  endtask

  task automatic test_mask();
    do_reset();
    axis = 3'b100; mask = 3'b011;
    repeat (100) begin
      tick();
      n_chk++;
      if (blk !== 3'b000) begin n_fail++; $display("FAIL mask_off_block got %b exp 000", blk); end
    end
    mask = 3'b111;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_chk++;
      if (blk[0] !== (e == 4)) begin n_fail++; $display("FAIL mask_on_block edge=%0d got %b exp %b", e, blk[0], e == 4); end
    end
    n_chk++;
    if (src_o[0] !== 2'd2) begin n_fail++; $display("FAIL mask_src got %0d exp 2", src_o[0]); end
  endtask

  task automatic test_clear();
    do_reset();
    axis = 3'b001;
    repeat (4) tick();
    axis = 3'b000;
    tick();
    axis = 3'b001;
    repeat (3) tick();
    clear = 1;
    tick();
    clear = 0;
    n_chk += 3;
    if (blk[0] !== 1'b1) begin n_fail++; $display("FAIL clear_entry_block got %b exp 1", blk[0]); end
    if (stk[0] !== 1'b1) begin n_fail++; $display("FAIL clear_entry_sticky got %b exp 1", stk[0]); end
    if (ev[0] !== 16'd1) begin n_fail++; $display("FAIL clear_entry_evt got %0d exp 1", ev[0]); end
    clear = 1;
    tick();
    clear = 0;
    n_chk += 3;
    if (blk[0] !== 1'b1) begin n_fail++; $display("FAIL clear_only_block got %b exp 1", blk[0]); end
    if (stk[0] !== 1'b0) begin n_fail++; $display("FAIL clear_only_sticky got %b exp 0", stk[0]); end
    if (ev[0] !== 16'd0) begin n_fail++; $display("FAIL clear_only_evt got %0d exp 0", ev[0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    axis = 3'b001;
    repeat (3) tick();
    reset = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({blk[k], stk[k], src_o[k], ev[k]} !== 20'd0)
        begin n_fail++; $display("FAIL midreset_outs k=%0d got %b/%b/%0d/%0d exp zeros", k, blk[k], stk[k], src_o[k], ev[k]); end
    end
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_chk++;
      if (blk[0] !== (e == 4)) begin n_fail++; $display("FAIL midreset_block edge=%0d got %b exp %b", e, blk[0], e == 4); end
    end
  endtask

  task automatic test_inst();
    do_reset();
    axis = 3'b000; idle = 5'b11111; iblk = 2'b10;
    for (int e = 1; e <= 2; e++) begin
      tick();
      n_chk++;
`ifdef DEADLOCK_MON_INST_EN
      if (blk[1] !== (e == 2)) begin n_fail++; $display("FAIL inst_block edge=%0d got %b exp %b", e, blk[1], e == 2); end
`else
      if (blk[1] !== 1'b0) begin n_fail++; $display("FAIL inst_block edge=%0d got %b exp 0", e, blk[1]); end
`endif
    end
    n_chk++;
`ifdef DEADLOCK_MON_INST_EN
    if (src_o[1] !== 2'd3) begin n_fail++; $display("FAIL inst_src got %0d exp 3", src_o[1]); end
`else
    if (src_o[1] !== 2'd0) begin n_fail++; $display("FAIL inst_src got %0d exp 0", src_o[1]); end
`endif
    idle = 0; iblk = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      axis = 3'($urandom) | ($urandom_range(0, 3) != 0 ? 3'b001 : 3'b000);
      if ($urandom_range(0, 15) == 0) axis = 3'b000;
      if ($urandom_range(0, 31) == 0) mask = 3'($urandom);
      idle = ($urandom_range(0, 3) == 0) ? 5'b11111 : 5'($urandom);
      iblk = 2'($urandom);
      clear = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 199) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (blk[k] !== (run[k] >= th(k)) || stk[k] !== m_stk[k] || src_o[k] !== 2'(m_src[k]) || ev[k] !== 16'(m_evt[k])) begin
          n_fail++;
          $display("FAIL random c=%0d k=%0d got blk=%b stk=%b src=%0d evt=%0d exp blk=%b stk=%b src=%0d evt=%0d",
                   c, k, blk[k], stk[k], src_o[k], ev[k], run[k] >= th(k), m_stk[k], m_src[k], m_evt[k]);
        end
      end
    end
    reset = 0; clear = 0;
  endtask

  initial begin
    test_reset();
    test_persist();
    test_restart();
    test_mask();
    test_clear();
    test_reset_mid();
    test_inst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/deadlock_persist_monitor.md
DEADLOCK_PERSIST_MONITOR -- requirements
Module: deadlock_persist_monitor

Interface
REQ-001 SHALL have parameter N_AXIS, default 3: number of AXIS block-signal inputs.
REQ-002 SHALL have parameter N_INST, default 5: number of instance idle-signal inputs.
REQ-003 SHALL have parameter N_IBLK, default 2: number of instance block-signal inputs.
REQ-004 SHALL have parameter THRESH, default 16, legal range 1..65535: consecutive candidate cycles required before declaring a block.
REQ-005 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port axis_block_sigs, input, N_AXIS: per-stream blocked indication.
REQ-008 SHALL have port axis_mask, input, N_AXIS: 1 = stream monitored.
REQ-009 SHALL have port inst_idle_sigs, input, N_INST: per-instance idle.
REQ-010 SHALL have port inst_block_sigs, input, N_IBLK: per-instance blocked.
REQ-011 SHALL have port clear, input, 1: one-cycle pulse that clears the sticky status.
REQ-012 SHALL have port block, output, 1: live deadlock flag.
REQ-013 SHALL have port block_sticky, output, 1: latched deadlock flag.
REQ-014 SHALL have port block_src, output, SRC_W = clog2(N_AXIS+1): source index of the current or last block.
REQ-015 SHALL have port event_cnt, output, 16: saturating count of block declarations.

Function
REQ-016 SHALL compute cand = OR(axis_block_sigs AND axis_mask), OR-ed with inst_dl when DEADLOCK_MON_INST_EN is defined (REQ-029).
REQ-017 SHALL implement an FSM with states IDLE, COUNT and BLOCKED.
REQ-018 IDLE: on cand=1, SHALL go to COUNT with cnt=1 and capture block_src; if THRESH=1, SHALL go directly to BLOCKED.
REQ-019 COUNT: on cand=1, SHALL increment cnt; on reaching cnt=THRESH, SHALL go to BLOCKED; on cand=0, SHALL go to IDLE with cnt=0.
REQ-020 BLOCKED: block SHALL be 1; on cand=0, SHALL go to IDLE with block=0 on the next edge.
REQ-021 block SHALL be a registered output: it rises on the edge at which cand has been sampled high on THRESH consecutive edges (THRESH=1 gives one-cycle registered latency).
REQ-022 block_src SHALL be the lowest masked asserted axis index at COUNT entry, or N_AXIS if only inst_dl is true; it SHALL hold until the next COUNT entry.
REQ-023 Any single cand=0 cycle SHALL fully restart the persistence count (no hysteresis).
REQ-024 Each entry to BLOCKED SHALL set block_sticky and increment event_cnt, saturating at 0xFFFF.
REQ-025 clear SHALL zero block_sticky and event_cnt; on a simultaneous BLOCKED entry, sticky SHALL read 1 and event_cnt SHALL read 1; clear SHALL NOT affect the FSM, block or block_src.
REQ-026 axis_mask changes SHALL take effect in the same cycle's cand; a mask change that drops cand SHALL restart the count.

Reset
REQ-027 On reset=1 at a rising edge, SHALL set FSM=IDLE, cnt=0, block=0, block_sticky=0, block_src=0, event_cnt=0.
REQ-028 Reset SHALL take priority over all inputs, including mid-COUNT or BLOCKED state; cand is re-evaluated from IDLE after release.

Configuration
REQ-029 With DEADLOCK_MON_INST_EN defined, SHALL compute inst_dl = OR(inst_block_sigs) AND AND(inst_idle_sigs) as an extra cand source.
REQ-030 Without DEADLOCK_MON_INST_EN, inst_idle_sigs and inst_block_sigs SHALL be ignored and block_src SHALL never equal N_AXIS.

Structure
REQ-031 SHALL place the FSM state enum, the SRC_W function/constant and the EVT_W=16 constant in shared package deadlock_mon_pkg.
REQ-032 SHALL implement a sub-module deadlock_prio_enc (parametrised lowest-index priority encoder with valid flag) for block_src; all other logic SHALL be flat.

Verification
REQ-033 THRESH=4, mask=3'b111, axis[1] held high from cycle 0: block SHALL rise at edge 4, block_src=1, event_cnt=1, block_sticky=1.
REQ-034 THRESH=4, axis[0] high 3 cycles, low 1 cycle, high 4 cycles: block SHALL assert only after the second burst, and event_cnt SHALL equal 1.
REQ-035 axis[2] high with mask[2]=0: block SHALL remain 0 for 100 cycles; setting mask[2]=1 SHALL assert block THRESH edges later.
REQ-036 While BLOCKED, pulse clear in the same cycle as a new BLOCKED entry: block_sticky SHALL be 1 and event_cnt SHALL be 1; a clear pulse alone SHALL zero both while block stays 1.
REQ-037 Assert reset mid-COUNT (cnt=3 of 4) with axis held high: all outputs SHALL be 0 on the next edge, and block SHALL rise exactly 4 edges after reset release.
REQ-038 With DEADLOCK_MON_INST_EN, inst_idle=5'b11111, inst_block=2'b10, axis=0, THRESH=2: block SHALL rise at edge 2 with block_src=3; without the macro, block SHALL stay 0.
